// File: rtl/uart_echo_fifo_pkg.sv
// uart_echo_fifo_pkg
//   Shared definitions for the serial echo path: RX/TX state encodings,
//   counter-width helper and default bit-period dividers for a 48 MHz mclk.
package uart_echo_fifo_pkg;

    // mclk cycles per bit at 48 MHz
    localparam int CLK_DIV_48M_1M = 48;
    localparam int CLK_DIV_48M_3M = 16;

    localparam logic [2:0] RX_IDLE      = 3'd0;
    localparam logic [2:0] RX_START     = 3'd1;
    localparam logic [2:0] RX_DATA      = 3'd2;
    localparam logic [2:0] RX_STOP      = 3'd3;
    localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    // Width of a counter that must hold 0..n-1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_echo_fifo_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with show-ahead output. Pointers carry one extra wrap
//   bit so full/empty come from the MSB comparison and level = wptr - rptr.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (empties the FIFO)
//   wr_en, din   push request / data
//   rd_en, dout  pop request / head data (valid while !empty)
//   full, empty  status
//   level        occupancy 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_bypass;
    logic             w_do_wr;
    logic             w_do_rd;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign level = r_wptr - r_rptr;

    // Push+pop on an empty FIFO passes din straight through; on a full FIFO
    // the write lands in the slot being vacated. Either way level holds.
    assign w_bypass = empty && wr_en && rd_en;
    assign w_do_wr  = wr_en && (!full || rd_en) && !w_bypass;
    assign w_do_rd  = rd_en && !empty;
    assign dout     = w_bypass ? din : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_wr) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_rd) r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo
//   UART receiver + TX FIFO + transmitter with internal bit timing from mclk.
//   Valid received characters are optionally echoed through the FIFO; local
//   logic may also inject characters. Errors are sticky until clear_errors.
// Ports:
//   mclk, reset            clock, asynchronous active-high reset
//   serial_rx / serial_tx  FTDI serial lines (idle high)
//   echo_en                push each valid RX character into the FIFO
//   rx_data, rx_strobe     last received character, one-cycle update pulse
//   tx_data, tx_strobe     local push request; tx_ready = accepted this cycle
//   fifo_level             FIFO occupancy
//   overflow, frame_error  sticky error flags; clear_errors clears both
module uart_echo_fifo
    import uart_echo_fifo_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_48M_1M,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                          mclk,
    input  logic                          reset,
    input  logic                          serial_rx,
    output logic                          serial_tx,
    input  logic                          echo_en,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_strobe,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_strobe,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_error,
    input  logic                          clear_errors
);
    localparam int CW = cnt_width(CLK_DIV * STOP_BITS);
    localparam int BW = cnt_width(DATA_BITS);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLK_DIV/2 - 1);
    localparam logic [CW-1:0] BIT_M1   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] STOP_M1  = CW'(CLK_DIV*STOP_BITS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    // ---------------- receiver ----------------
    logic                 r_rx_s1, r_rx_s2, r_rx_prev;
    logic [2:0]           r_rx_state;
    logic [CW-1:0]        r_rx_cnt;
    logic [BW-1:0]        r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_strobe;
    logic                 w_fe_set;

    assign w_fe_set = (r_rx_state == RX_STOP) && (r_rx_cnt == BIT_M1) && !r_rx_s2;

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_rx_state  <= RX_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_strobe <= 1'b0;
        end else begin
            r_rx_s1     <= serial_rx;
            r_rx_s2     <= r_rx_s1;
            r_rx_prev   <= r_rx_s2;
            r_rx_strobe <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    // falling edge, not a held-low level
                    if (r_rx_prev && !r_rx_s2) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_M1) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == BIT_M1) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == LAST_BIT) r_rx_state <= RX_STOP;
                        else                      r_rx_bit   <= r_rx_bit + BIT_ONE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == BIT_M1) begin
                        r_rx_cnt <= '0;
                        if (r_rx_s2) begin
                            r_rx_data   <= r_rx_shift;
                            r_rx_strobe <= 1'b1;
                            r_rx_state  <= RX_IDLE;
                        end else begin
                            r_rx_state  <= RX_WAIT_HIGH;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_ONE;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (r_rx_s2) r_rx_state <= RX_IDLE;
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- FIFO push arbitration ----------------
    logic                 w_full, w_empty;
    logic                 w_echo, w_local, w_wr_en, w_rd_en;
    logic [DATA_BITS-1:0] w_din, w_dout;

    assign w_echo   = r_rx_strobe && echo_en;
    assign tx_ready = !w_full && !w_echo;
    assign w_local  = tx_strobe && tx_ready;
    assign w_wr_en  = (w_echo && !w_full) || w_local;
    assign w_din    = w_echo ? r_rx_data : tx_data;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (mclk),
        .rst   (reset),
        .wr_en (w_wr_en),
        .din   (w_din),
        .rd_en (w_rd_en),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    // ---------------- sticky errors (set beats clear) ----------------
    logic r_overflow, r_frame_error;

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_overflow    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            if (w_echo && w_full)  r_overflow <= 1'b1;
            else if (clear_errors) r_overflow <= 1'b0;
            if (w_fe_set)          r_frame_error <= 1'b1;
            else if (clear_errors) r_frame_error <= 1'b0;
        end
    end

    // ---------------- transmitter ----------------
    logic [1:0]           r_tx_state;
    logic [CW-1:0]        r_tx_cnt;
    logic [BW-1:0]        r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx;

    assign w_rd_en = (r_tx_state == TX_IDLE) && !w_empty;

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (!w_empty) begin
                        r_tx_shift <= w_dout;
                        r_tx       <= 1'b0;
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == BIT_M1) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == BIT_M1) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == LAST_BIT) begin
                            r_tx       <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_bit   <= r_tx_bit + BIT_ONE;
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_ONE;
                    end
                end
                TX_STOP: begin
                    if (r_tx_cnt == STOP_M1) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_ONE;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign serial_tx   = r_tx;
    assign rx_data     = r_rx_data;
    assign rx_strobe   = r_rx_strobe;
    assign overflow    = r_overflow;
    assign frame_error = r_frame_error;

endmodule

// File: tb/tb_uart_echo_fifo.sv
module tb_uart_echo_fifo;
    localparam int CLK_DIV = 48;
    localparam int DEPTH   = 4;
    localparam int NSTOP   = 2;
    // one pop cycle plus start, 8 data and NSTOP stop bits
    localparam int PERIOD  = 1 + (1 + 8 + NSTOP) * CLK_DIV;

    logic       mclk = 1'b0;
    logic       reset = 1'b1;
    logic       serial_rx = 1'b1;
    logic       serial_tx;
    logic       echo_en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_strobe = 1'b0;
    logic       tx_ready;
    logic [$clog2(DEPTH):0] fifo_level;
    logic       overflow;
    logic       frame_error;
    logic       clear_errors = 1'b0;

    uart_echo_fifo #(
        .CLK_DIV    (CLK_DIV),
        .DATA_BITS  (8),
        .FIFO_DEPTH (DEPTH),
        .STOP_BITS  (NSTOP)
    ) dut (
        .mclk         (mclk),
        .reset        (reset),
        .serial_rx    (serial_rx),
        .serial_tx    (serial_tx),
        .echo_en      (echo_en),
        .rx_data      (rx_data),
        .rx_strobe    (rx_strobe),
        .tx_data      (tx_data),
        .tx_strobe    (tx_strobe),
        .tx_ready     (tx_ready),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .frame_error  (frame_error),
        .clear_errors (clear_errors)
    );

    always #5 mclk = ~mclk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];        // FIFO contents
    logic [7:0] exp_rx[$];    // characters whose strobe is due
    int         cyc = 0;
    int         last_pop = 0;
    bit         have_frame = 0;
    logic [7:0] cur_byte = 8'h00;
    bit         m_ovf = 0;
    bit         m_fe = 0;
    bit         fe_pending = 0;
    logic [7:0] rx_last = 8'h00;

    function automatic logic exp_tx();
        int t;
        if (!have_frame) return 1'b1;
        t = cyc - (last_pop + 1);
        if (t < 0) return 1'b1;
        if (t < CLK_DIV) return 1'b0;
        if (t < CLK_DIV * 9) return cur_byte[(t / CLK_DIV) - 1];
        return 1'b1;
    endfunction

    // compare + model step, mid-cycle after all drivers have settled
    initial begin
        bit echo, full;
        forever begin
            @(negedge mclk);
            #3;
            cyc++;
            if (reset) begin
                mq.delete();
                have_frame = 0;
                m_ovf = 0;
                m_fe = 0;
                rx_last = 8'h00;
                chk("rst_serial_tx", serial_tx, 1);
                chk("rst_fifo_level", fifo_level, 0);
                chk("rst_overflow", overflow, 0);
                chk("rst_frame_error", frame_error, 0);
                chk("rst_rx_strobe", rx_strobe, 0);
                chk("rst_rx_data", rx_data, 0);
            end else begin
                echo = rx_strobe && echo_en;
                full = (mq.size() == DEPTH);
                chk("serial_tx", serial_tx, exp_tx());
                chk("fifo_level", fifo_level, mq.size());
                chk("tx_ready", tx_ready, !full && !echo);
                chk("overflow", overflow, m_ovf);
                if (!fe_pending) chk("frame_error", frame_error, m_fe);
                if (rx_strobe) begin
                    if (exp_rx.size() == 0) chk("rx_strobe_unexpected", 1, 0);
                    else rx_last = exp_rx.pop_front();
                end
                chk("rx_data", rx_data, rx_last);
                if (mq.size() > 0 && (!have_frame || cyc >= last_pop + PERIOD)) begin
                    cur_byte = mq.pop_front();
                    last_pop = cyc;
                    have_frame = 1;
                end
                if (echo && full) m_ovf = 1;
                else if (clear_errors) m_ovf = 0;
                if (echo && !full) mq.push_back(rx_last);
                if (tx_strobe && !full && !echo) mq.push_back(tx_data);
                if (clear_errors && !fe_pending) m_fe = 0;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic wait_until_cyc(input int target);
        forever begin
            @(negedge mclk);
            #4;
            if (cyc >= target) break;
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input bit good);
        serial_rx = 1'b0;
        wait_cyc(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            serial_rx = b[i];
            wait_cyc(CLK_DIV);
        end
        if (good) exp_rx.push_back(b);
        else fe_pending = 1;
        serial_rx = good;
        wait_cyc(CLK_DIV);
        if (good) begin
            chk("rx_strobe_seen", exp_rx.size(), 0);
            exp_rx.delete();
        end else begin
            m_fe = 1;
            fe_pending = 0;
        end
    endtask

    task automatic push_local(input logic [7:0] b);
        bit ok;
        ok = 0;
        tx_data = b;
        tx_strobe = 1'b1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge mclk);
            #2;
            if (tx_ready) ok = 1;
        end
        @(posedge mclk);
        #1;
        tx_strobe = 1'b0;
        chk("push_accepted", ok, 1);
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        wait_cyc(1);
        clear_errors = 1'b0;
    endtask

    task automatic wait_tx_idle();
        bit idle;
        idle = 0;
        for (int i = 0; i < 20000; i++) begin
            if (mq.size() == 0 && (!have_frame || cyc >= last_pop + PERIOD)) begin
                idle = 1;
                break;
            end
            wait_cyc(1);
        end
        chk("tx_drain", idle, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        bit rnd_done;
        rnd_done = 0;
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(4);

        // echo of 0x55
        echo_en = 1'b1;
        send_rx(8'h55, 1);
        chk("t1_rx_data", rx_data, 8'h55);
        wait_until_cyc(last_pop + 1 + CLK_DIV/2);
        chk("t1_start_bit", serial_tx, 0);
        for (int i = 0; i < 8; i++) begin
            wait_until_cyc(last_pop + 1 + CLK_DIV*(i+1) + CLK_DIV/2);
            chk("t1_data_bit", serial_tx, pat[i]);
        end
        wait_until_cyc(last_pop + 1 + CLK_DIV*9 + CLK_DIV/2);
        chk("t1_stop_bit", serial_tx, 1);
        @(posedge mclk); #1;
        wait_tx_idle();

        // frame error, line held low afterwards
        send_rx(8'hA3, 0);
        chk("t2_frame_error", frame_error, 1);
        chk("t2_fifo_level", fifo_level, 0);
        pulse_clear();
        wait_cyc(20 * CLK_DIV);
        chk("t2_no_retrigger", frame_error, 0);
        serial_rx = 1'b1;
        wait_cyc(10);

        // glitch rejection
        serial_rx = 1'b0;
        wait_cyc(10);
        serial_rx = 1'b1;
        wait_cyc(100);
        chk("t5_no_fe", frame_error, 0);
        chk("t5_no_strobe", rx_data, 8'h55);

        // push collision
        wait_tx_idle();
        fork
            send_rx(8'h42, 1);
            begin
                bit seen;
                seen = 0;
                for (int i = 0; i < 2000 && !seen; i++) begin
                    @(negedge mclk);
                    #1;
                    if (rx_strobe) seen = 1;
                end
                chk("t4_strobe_seen", seen, 1);
                tx_data = 8'h41;
                tx_strobe = 1'b1;
                #1;
                chk("t4_tx_ready_low", tx_ready, 0);
                push_local(8'h41);
            end
        join
        chk("t4_first_tx", cur_byte, 8'h42);
        wait_tx_idle();
        chk("t4_last_tx", cur_byte, 8'h41);

        // overflow with a full FIFO
        push_local(8'hF0);
        for (int i = 1; i <= 4; i++) push_local(8'(i));
        chk("t3_level_full", fifo_level, 4);
        chk("t3_tx_ready_full", tx_ready, 0);
        tx_data = 8'h05;
        tx_strobe = 1'b1;
        wait_cyc(3);
        tx_strobe = 1'b0;
        send_rx(8'h7E, 1);
        chk("t3_overflow", overflow, 1);
        wait_tx_idle();
        pulse_clear();
        chk("t3_overflow_clr", overflow, 0);

        // randomized traffic
        fork
            begin
                logic [7:0] b;
                bit good;
                for (int k = 0; k < 10; k++) begin
                    echo_en = ($urandom_range(0, 3) != 0);
                    b = 8'($urandom_range(0, 255));
                    good = ($urandom_range(0, 4) != 0);
                    send_rx(b, good);
                    if (!good) wait_cyc($urandom_range(0, 60));
                    serial_rx = 1'b1;
                    wait_cyc($urandom_range(3, 40));
                end
                rnd_done = 1;
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    wait_cyc($urandom_range(50, 400));
                    push_local(8'($urandom_range(0, 255)));
                end
            end
            begin
                while (!rnd_done) begin
                    wait_cyc($urandom_range(100, 500));
                    if (!fe_pending && !rnd_done) pulse_clear();
                end
            end
        join
        wait_tx_idle();

        // reset during data bit 3 of 0xC3
        echo_en = 1'b0;
        push_local(8'hC3);
        push_local(8'h11);
        wait_until_cyc(last_pop + 1 + CLK_DIV*4 + 10);
        chk("t6_bit3_low", serial_tx, 0);
        @(posedge mclk); #1;
        reset = 1'b1;
        #1;
        chk("t6_tx_high", serial_tx, 1);
        chk("t6_level_zero", fifo_level, 0);
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2 * PERIOD);
        chk("t6_no_stale", serial_tx, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
Parametrised successor to the fixed-rate serial echo path. It integrates the receiver, a buffering FIFO and the transmitter, and generates its baud timing internally from mclk, so no external divided baud clocks are needed. Received bytes are optionally echoed through the FIFO. Local logic can also inject bytes for transmission and observe the receive stream. Errors are reported through sticky flags. It sits between the FTDI serial pins and the top-level design logic.

Parameters:
CLK_DIV, 48, mclk cycles per bit (48 gives 1 Mb/s at 48 MHz); must be ≥8 and even.
DATA_BITS, 8, bits per character, LSB first, range 5..8.
FIFO_DEPTH, 16, TX FIFO entries; power of two, ≥2.
STOP_BITS, 1, transmitted stop bits (1 or 2); the receiver checks only one.

Ports:
mclk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
serial_rx  in  1  line from the FTDI chip; idles high; asynchronous to mclk.
serial_tx  out  1  line to the FTDI chip; idles high.
echo_en  in  1  1 = push each valid received character into the FIFO.
rx_data  out  DATA_BITS  last valid received character.
rx_strobe  out  1  one-cycle pulse when rx_data updates.
tx_data  in  DATA_BITS  locally injected character.
tx_strobe  in  1  request to push tx_data into the FIFO.
tx_ready  out  1  tx_strobe is accepted this cycle.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
overflow  out  1  sticky: an echo push was dropped because the FIFO was full.
frame_error  out  1  sticky: a received stop bit sampled low.
clear_errors  in  1  synchronous clear of overflow and frame_error.

Behaviour:
- Reset values: serial_tx=1, rx_data=0, rx_strobe=0, fifo_level=0, overflow=0, frame_error=0. The FIFO is emptied.
- Reset mid-frame: serial_tx returns high immediately; the partial RX and TX frames are discarded.
- RX input: serial_rx passes through a 2-flop synchroniser. Only the synchronised value is used.
- RX states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a high→low transition starts a counter.
  - START: at CLK_DIV/2 the line is re-sampled. If high, the start is treated as a glitch and the receiver returns to IDLE.
  - DATA: DATA_BITS samples, taken every CLK_DIV cycles at bit centres.
  - STOP: one sample. High → rx_data loads and rx_strobe pulses the next cycle. Low → frame_error is set, no strobe is issued, and the receiver enters WAIT_HIGH.
  - WAIT_HIGH: wait until the line is high, so that a break condition does not retrigger the receiver.
- Echo push: occurs in the cycle rx_strobe is high, when echo_en=1.
  - FIFO full → the character is dropped and overflow is set.
  - echo_en=0 → nothing is pushed and overflow is unaffected.
- Local push: tx_ready = !full && !(rx_strobe && echo_en). This is combinational, and the echo push has priority. A push happens when tx_strobe && tx_ready. A rejected tx_strobe is not an overflow; the requester retries.
- Simultaneous push and pop in one cycle: fifo_level is unchanged, including when the FIFO is full or empty at the start of that cycle.
- TX states: IDLE → START → DATA → STOP → IDLE.
  - IDLE with the FIFO non-empty: pop the head.
  - serial_tx goes low on the next cycle and stays low for CLK_DIV cycles.
  - DATA_BITS data bits follow, LSB first, CLK_DIV cycles each.
  - STOP_BITS×CLK_DIV cycles high follow.
  - Back-to-back characters: no idle gap beyond the single pop cycle.
- Sticky flags: clear_errors clears them in one cycle. If a new error and clear_errors occur in the same cycle, the set wins.
- fifo_level range is 0..FIFO_DEPTH. The pointers are $clog2(FIFO_DEPTH)+1 bits wide; full and empty are derived from the MSB.

Decomposition:
- Shared include uart_defs.v holds:
  - RX/TX state encodings;
  - the bit-counter width helper;
  - the default CLK_DIV for 48 MHz at 1 Mb/s and 3 Mb/s.
- Sub-module sync_fifo holds the FIFO storage (parameters WIDTH, DEPTH; ports wr_en, din, rd_en, dout, full, empty, level). It is reused elsewhere.
- The RX and TX state machines stay inline.

Test Plan:
1. Echo, default parameters: echo_en=1; drive 0x55 on serial_rx with 48-cycle bits.
   - rx_strobe fires once, with rx_data=0x55.
   - serial_tx emits start, then 1,0,1,0,1,0,1,0, then stop, each bit 48 cycles.
2. Frame error: send 0xA3 with the stop bit held low.
   - frame_error=1, no rx_strobe, fifo_level stays 0.
   - Holding the line low for 2 frames causes no retrigger.
   - clear_errors pulse → frame_error=0.
3. Overflow, FIFO_DEPTH=4, STOP_BITS=2:
   - Inject 4 local bytes (0x01..0x04) while serial_tx is busy. tx_ready drops once the FIFO is full.
   - Then receive 0x7E with the FIFO full → overflow=1; 0x7E is never transmitted.
4. Push collision: assert tx_strobe (0x41) in the same cycle as an echo rx_strobe (0x42).
   - tx_ready=0 that cycle; 0x42 is queued.
   - The retried 0x41 is transmitted after 0x42.
5. Glitch rejection: a 10-cycle low pulse on serial_rx.
   - No rx_strobe, no frame_error.
6. Reset mid-transmit: assert reset during data bit 3 of 0xC3.
   - serial_tx=1 immediately and fifo_level=0.
   - After reset, no stale character is transmitted.
